control_fsm: RTL
================

// Module: control_fsm
// PURPOSE
//  Multicycle main control unit for the 64-bit RISC-V datapath; drives every datapath control flag.
//  Consumes the latched instruction word and the ALU zero flag.
//  Moore FSM sequencing fetch/decode/execute/memory/writeback for add, sub, and, addi, ld, sd, beq.
//  Unknown opcodes halt the core. Adds a retired-instruction counter and a halt flag for the bench.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter
// PORTS
//  clk          in   1      core clock; all state updates on rising edge
//  reset        in   1      asynchronous, active-low reset
//  instruction  in   32     instruction-register contents
//  alu_zero     in   1      ALU zero flag, combinational from the datapath
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load qualified by alu_zero
//  PCSource     out  1      0=ALU result, 1=ALUOut register
//  ALUSrcA      out  1      0=PC, 1=reg A
//  ALUSrcB      out  2      00=reg B, 01=const 4, 10=imm, 11=imm*2
//  ALUOp        out  3      ALU function (ctrl_pkg::alu_op_t)
//  LoadAOut     out  1      load ALUOut register
//  RegWrite     out  1      regfile write
//  LoadRegA     out  1      load A register
//  LoadRegB     out  1      load B register
//  MemToReg     out  1      0=ALU result, 1=MDR
//  DMemOp       out  1      data-memory write
//  LoadMDR      out  1      MDR load (asserted in LD_ADDR)
//  IMemRead     out  1      instruction-memory read
//  IRWrite      out  1      instruction-register load
//  halted       out  1      sticky; set on illegal instruction
//  state_out    out  4      current state encoding (debug)
//  retired      out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; retired=0; halted=0.
//   - All flags are 0 in IDLE.
//  IDLE -> FETCH unconditionally, one cycle after reset release.
//  Flags are decoded from the state only. Any flag not listed for a state is 0.
//   FETCH:    IMemRead, IRWrite                            -> DECODE
//   DECODE:   LoadRegA, LoadRegB, ALUSrcA=0, ALUSrcB=11, ADD, LoadAOut (branch target)
//             next state by opcode[6:0]:
//               0110011 -> EXEC_R; 0010011 (funct3=000) -> EXEC_I; 0000011 (funct3=011) -> LD_ADDR
//               0100011 (funct3=011) -> SD_MEM; 1100011 (funct3=000) -> BRANCH; else -> HALT
//   EXEC_R:   ALUSrcA=1, ALUSrcB=00, RegWrite, MemToReg=0  -> NEXT_PC
//             ALUOp from funct3/funct7:
//               000/0000000=ADD, 000/0100000=SUB, 111/0000000=AND; any other combination -> HALT
//               (no write in that case)
//   EXEC_I:   ALUSrcA=1, ALUSrcB=10, ADD, RegWrite          -> NEXT_PC
//   LD_ADDR:  ALUSrcA=1, ALUSrcB=10, ADD, LoadMDR           -> LD_WB
//   LD_WB:    RegWrite, MemToReg=1                          -> NEXT_PC
//   SD_MEM:   ALUSrcA=1, ALUSrcB=10, ADD, DMemOp            -> NEXT_PC
//   BRANCH:   ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSource=1
//             alu_zero=1 -> FETCH (retire); alu_zero=0 -> NEXT_PC
//   NEXT_PC:  ALUSrcA=0, ALUSrcB=01, ADD, PCWrite, PCSource=0 -> FETCH (retire)
//   HALT:     all flags 0; halted=1; stays in HALT until reset
//  Retire:
//   - retired increments by 1 on each NEXT_PC->FETCH and taken BRANCH->FETCH edge.
//   - Wraps modulo 2^CNT_W; no saturation.
//  Latency: R/I/sd = 4 cycles; ld = 5; beq taken = 3, not taken = 4.
//  Instruction decode uses the instruction port value sampled in DECODE; the IR is stable from then on.
//  Reset asserted mid-instruction:
//   - Immediately forces IDLE and all flags 0; any pending write is abandoned.
//   - halted and retired are cleared.
//  Illegal encoding: no RegWrite/DMemOp/PCWrite is ever issued for it.
// STRUCTURE
//  ctrl_pkg:
//   - state_t enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, LD_ADDR, LD_WB, SD_MEM, BRANCH, NEXT_PC, HALT), 4 bits.
//   - alu_op_t: ADD=3'b001, SUB=3'b010, AND=3'b011.
//   - Opcode/funct constants; ALUSrcB select constants.
//  Sub-module ctrl_alu_decode: combinational funct3/funct7 -> {alu_op_t, illegal}; used in EXEC_R.
//  Top keeps the state register, next-state logic, output decode and the retire counter.
// TESTING
//  1. Hold reset low 3 cycles, release:
//     all flags 0 during reset and IDLE; FETCH on 2nd edge asserts IMemRead=IRWrite=1.
//  2. add x3,x1,x2 (0x002081B3):
//     FETCH, DECODE, EXEC_R, NEXT_PC; EXEC_R shows ALUOp=001, RegWrite=1; retired 0->1.
//  3. ld x5,8(x1) (0x0080B283):
//     LD_WB has MemToReg=1, RegWrite=1; 5 cycles FETCH-to-FETCH.
//  4. beq x1,x2,+16 (0x00208863):
//     alu_zero=1 -> PCWriteCond=1, PCSource=1 in BRANCH, next state FETCH;
//     alu_zero=0 -> next state NEXT_PC.
//  5. Opcode 0x7F, or sub with funct7=0x01:
//     enters HALT, halted=1; no RegWrite in any later cycle; recovers only via reset.
//  6. Pull reset low in LD_WB:
//     RegWrite drops the same cycle; state_out=IDLE and retired=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V main control unit.
// States, ALU functions, opcode/funct fields and ALU operand selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    EXEC_I  = 4'd4,
    LD_ADDR = 4'd5,
    LD_WB   = 4'd6,
    SD_MEM  = 4'd7,
    BRANCH  = 4'd8,
    NEXT_PC = 4'd9,
    HALT    = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011
  } alu_op_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  // Instruction class selection out of DECODE.
  function automatic state_t decode_next(
    input logic [6:0] opcode,
    input logic [2:0] funct3
  );
    state_t s;
    s = HALT;
    unique case (1'b1)
      (opcode == OP_RTYPE):
        s = EXEC_R;
      (opcode == OP_IMM && funct3 == F3_ADD):
        s = EXEC_I;
      (opcode == OP_LOAD && funct3 == F3_LD):
        s = LD_ADDR;
      (opcode == OP_STORE && funct3 == F3_SD):
        s = SD_MEM;
      (opcode == OP_BRANCH && funct3 == F3_BEQ):
        s = BRANCH;
      default:
        s = HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the main control unit and the datapath.
// The control unit is the master; the datapath (or bench) is the slave.
interface control_fsm_if #(
  parameter int CNT_W = 32
) ();

  logic [31:0]        instruction;
  logic               alu_zero;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               PCSource;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  ctrl_pkg::alu_op_t  ALUOp;
  logic               LoadAOut;
  logic               RegWrite;
  logic               LoadRegA;
  logic               LoadRegB;
  logic               MemToReg;
  logic               DMemOp;
  logic               LoadMDR;
  logic               IMemRead;
  logic               IRWrite;
  logic               halted;
  logic [3:0]         state_out;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  instruction, alu_zero,
    output PCWrite, PCWriteCond, PCSource,
    output ALUSrcA, ALUSrcB, ALUOp,
    output LoadAOut, RegWrite,
    output LoadRegA, LoadRegB,
    output MemToReg, DMemOp, LoadMDR,
    output IMemRead, IRWrite,
    output halted, state_out, retired
  );

  modport slave (
    output instruction, alu_zero,
    input  PCWrite, PCWriteCond, PCSource,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  LoadAOut, RegWrite,
    input  LoadRegA, LoadRegB,
    input  MemToReg, DMemOp, LoadMDR,
    input  IMemRead, IRWrite,
    input  halted, state_out, retired
  );

endinterface

// File: rtl/ctrl_alu_decode.sv
// R-type ALU function decode from funct3/funct7.
// Unsupported combinations are flagged so the FSM can halt without writing.
module ctrl_alu_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_NOP;
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == F3_ADD && funct7 == F7_BASE):
        alu_op = ALU_ADD;
      (funct3 == F3_ADD && funct7 == F7_SUB):
        alu_op = ALU_SUB;
      (funct3 == F3_AND && funct7 == F7_BASE):
        alu_op = ALU_AND;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle Moore main control unit with retire counter and halt flag.
// Flags decode from state; EXEC_R also gates on the R-type function decode.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] retired_q;
  logic             halted_q;
  logic             retire;

  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  alu_op_t     r_op;
  logic        r_illegal;
  logic        unused_ir;

  assign ir        = bus.instruction;
  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  ctrl_alu_decode u_alu_dec (
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_op  (r_op),
    .illegal (r_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = decode_next(opcode, funct3);
      EXEC_R:  state_d = r_illegal ? HALT : NEXT_PC;
      EXEC_I:  state_d = NEXT_PC;
      LD_ADDR: state_d = LD_WB;
      LD_WB:   state_d = NEXT_PC;
      SD_MEM:  state_d = NEXT_PC;
      BRANCH: begin
        state_d = bus.alu_zero ? FETCH : NEXT_PC;
        retire  = bus.alu_zero;
      end
      NEXT_PC: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Sticky: raised together with the entry into HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else if (state_d == HALT) begin
      halted_q <= 1'b1;
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCSource    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REG;
    bus.ALUOp       = ALU_NOP;
    bus.LoadAOut    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.LoadRegA    = 1'b0;
    bus.LoadRegB    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.DMemOp      = 1'b0;
    bus.LoadMDR     = 1'b0;
    bus.IMemRead    = 1'b0;
    bus.IRWrite     = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.IMemRead = 1'b1;
        bus.IRWrite  = 1'b1;
      end
      DECODE: begin
        bus.LoadRegA = 1'b1;
        bus.LoadRegB = 1'b1;
        bus.ALUSrcB  = SRCB_IMM2;
        bus.ALUOp    = ALU_ADD;
        bus.LoadAOut = 1'b1;
      end
      EXEC_R: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = SRCB_REG;
        bus.ALUOp    = r_illegal ? ALU_NOP : r_op;
        bus.RegWrite = !r_illegal;
      end
      EXEC_I: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = SRCB_IMM;
        bus.ALUOp    = ALU_ADD;
        bus.RegWrite = 1'b1;
      end
      LD_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALU_ADD;
        bus.LoadMDR = 1'b1;
      end
      LD_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
      end
      SD_MEM: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALU_ADD;
        bus.DMemOp  = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SRCB_REG;
        bus.ALUOp       = ALU_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 1'b1;
      end
      NEXT_PC: begin
        bus.ALUSrcB  = SRCB_FOUR;
        bus.ALUOp    = ALU_ADD;
        bus.PCWrite  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.halted    = halted_q;
  assign bus.state_out = state_q;
  assign bus.retired   = retired_q;

endmodule
